// File: rtl/oflow_cr_if.sv
// Conflict-resolver bundle: core_fsm control plus the PE score-board port.
//   master : core/PE side, drives start_cr, num_of_rows, score/id read data
//   slave  : oflow_conflict_resolve, drives row select, write strobe, done, count
interface oflow_cr_if #(
  parameter int ROW_LEN   = 3,
  parameter int SCORE_LEN = 16,
  parameter int ID_LEN    = 12
);
  logic                 start_cr;
  logic [ROW_LEN:0]     num_of_rows;
  logic [SCORE_LEN-1:0] score_to_cr_from_pe;
  logic [ID_LEN-1:0]    id_to_cr_from_pe;
  logic [ROW_LEN-1:0]   row_sel_to_pe_from_cr;
  logic                 write_to_pointer_to_pe;
  logic                 data_to_score_board_to_pe;
  logic [ROW_LEN-1:0]   row_to_change_to_pe;
  logic                 done_cr;
  logic [ROW_LEN:0]     conflict_cnt;

  modport master (
    output start_cr, num_of_rows, score_to_cr_from_pe, id_to_cr_from_pe,
    input  row_sel_to_pe_from_cr, write_to_pointer_to_pe, data_to_score_board_to_pe,
           row_to_change_to_pe, done_cr, conflict_cnt
  );

  modport slave (
    input  start_cr, num_of_rows, score_to_cr_from_pe, id_to_cr_from_pe,
    output row_sel_to_pe_from_cr, write_to_pointer_to_pe, data_to_score_board_to_pe,
           row_to_change_to_pe, done_cr, conflict_cnt
  );
endinterface

// File: rtl/oflow_conflict_resolve.sv
// Resolves ID conflicts among the score-board rows of one PE.
// A pass reads N rows (score, id) through row select, then walks every pair
// (i<j); rows sharing a valid ID conflict, the lower score loses (tie: j loses),
// and each loser is reported with a one-cycle write strobe to the PE.
// Ports:
//   clk     : rising-edge clock
//   reset_N : synchronous reset, active high
//   cr      : oflow_cr_if.slave (start/num_of_rows in, score/id in,
//             row select, write strobe/data/row, done pulse, conflict count out)
module oflow_conflict_resolve #(
  parameter int ROWS      = 8,
  parameter int ROW_LEN   = 3,
  parameter int SCORE_LEN = 16,
  parameter int ID_LEN    = 12
) (
  input  logic        clk,
  input  logic        reset_N,
  oflow_cr_if.slave   cr
);
  typedef enum logic [1:0] {IDLE, LOAD, COMPARE, DONE} state_t;

  localparam logic [ROW_LEN:0] ROWS_W = (ROW_LEN+1)'(ROWS);
  localparam logic [ROW_LEN:0] ONE    = (ROW_LEN+1)'(1);
  localparam logic [ROW_LEN:0] TWO    = (ROW_LEN+1)'(2);

  state_t               state;
  logic [ROW_LEN:0]     n_rows;
  logic [ROW_LEN:0]     cnt;
  logic [ROW_LEN:0]     idx_i;
  logic [ROW_LEN:0]     idx_j;
  logic [ROWS-1:0]      loser;
  logic                 drain;
  logic [SCORE_LEN-1:0] score_q [ROWS];
  logic [ID_LEN-1:0]    id_q    [ROWS];

  logic [ROW_LEN:0]     n_start;
  logic [ROW_LEN:0]     cnt_nxt;
  logic [ROW_LEN:0]     cap_idx;
  logic [ROW_LEN-1:0]   ri;
  logic [ROW_LEN-1:0]   rj;
  logic [ROW_LEN-1:0]   loser_row;
  logic                 pair_hit;
  logic                 last_j;
  logic                 last_pair;

  always_comb begin
    n_start   = (cr.num_of_rows > ROWS_W) ? ROWS_W : cr.num_of_rows;
    cnt_nxt   = cnt + ONE;
    cap_idx   = cnt - ONE;
    ri        = idx_i[ROW_LEN-1:0];
    rj        = idx_j[ROW_LEN-1:0];
    pair_hit  = (id_q[ri] == id_q[rj]) && (id_q[ri] != '1) && !loser[ri] && !loser[rj];
    loser_row = (score_q[rj] <= score_q[ri]) ? rj : ri;
    last_j    = (idx_j == n_rows - ONE);
    last_pair = last_j && (idx_i == n_rows - TWO);
  end

  always_ff @(posedge clk) begin
    if (reset_N) begin
      state                        <= IDLE;
      n_rows                       <= '0;
      cnt                          <= '0;
      idx_i                        <= '0;
      idx_j                        <= '0;
      loser                        <= '0;
      drain                        <= 1'b0;
      cr.row_sel_to_pe_from_cr     <= '0;
      cr.write_to_pointer_to_pe    <= 1'b0;
      cr.data_to_score_board_to_pe <= 1'b0;
      cr.row_to_change_to_pe       <= '0;
      cr.done_cr                   <= 1'b0;
      cr.conflict_cnt              <= '0;
    end else begin
      cr.write_to_pointer_to_pe    <= 1'b0;
      cr.data_to_score_board_to_pe <= 1'b0;
      cr.row_to_change_to_pe       <= '0;
      cr.done_cr                   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cr.start_cr) begin
            n_rows                   <= n_start;
            loser                    <= '0;
            cr.conflict_cnt          <= '0;
            cnt                      <= '0;
            cr.row_sel_to_pe_from_cr <= '0;
            if (n_start == '0) begin
              state      <= DONE;
              cr.done_cr <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          // PE data lags row select by one cycle, so cycle cnt holds row cnt-1.
          if (cnt != '0) begin
            score_q[cap_idx[ROW_LEN-1:0]] <= cr.score_to_cr_from_pe;
            id_q[cap_idx[ROW_LEN-1:0]]    <= cr.id_to_cr_from_pe;
          end
          if (cnt == n_rows) begin
            cnt                      <= '0;
            idx_i                    <= '0;
            idx_j                    <= ONE;
            cr.row_sel_to_pe_from_cr <= '0;
            if (n_rows == ONE) begin
              state      <= DONE;
              cr.done_cr <= 1'b1;
            end else begin
              state <= COMPARE;
            end
          end else begin
            cnt                      <= cnt_nxt;
            cr.row_sel_to_pe_from_cr <= (cnt_nxt < n_rows) ? cnt_nxt[ROW_LEN-1:0] : '0;
          end
        end
        COMPARE: begin
          // A conflict on the final pair strobes one cycle later, so stay one
          // extra cycle to keep done_cr strictly after that strobe.
          if (drain) begin
            drain      <= 1'b0;
            state      <= DONE;
            cr.done_cr <= 1'b1;
          end else begin
            if (pair_hit) begin
              loser[loser_row]             <= 1'b1;
              cr.conflict_cnt              <= cr.conflict_cnt + ONE;
              cr.write_to_pointer_to_pe    <= 1'b1;
              cr.data_to_score_board_to_pe <= 1'b1;
              cr.row_to_change_to_pe       <= loser_row;
            end
            if (last_pair) begin
              if (pair_hit) begin
                drain <= 1'b1;
              end else begin
                state      <= DONE;
                cr.done_cr <= 1'b1;
              end
            end else if (last_j) begin
              idx_i <= idx_i + ONE;
              idx_j <= idx_i + TWO;
            end else begin
              idx_j <= idx_j + ONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_oflow_conflict_resolve.sv
// Directed bench for oflow_conflict_resolve: a pair-walk model predicts losers,
// strobe cycles, done cycle and running count; every cycle of a pass is checked.
module tb_oflow_conflict_resolve;
  logic clk = 1'b0;
  logic reset_N;
  always #5 clk = ~clk;

  oflow_cr_if #(.ROW_LEN(3), .SCORE_LEN(16), .ID_LEN(12)) bus ();

  oflow_conflict_resolve #(.ROWS(8), .ROW_LEN(3), .SCORE_LEN(16), .ID_LEN(12)) dut (
    .clk     (clk),
    .reset_N (reset_N),
    .cr      (bus)
  );

  logic [11:0] tid [8];
  logic [15:0] tsc [8];

  // PE score-board: data for the selected row appears one cycle later.
  always @(posedge clk) begin
    bus.score_to_cr_from_pe <= tsc[bus.row_sel_to_pe_from_cr];
    bus.id_to_cr_from_pe    <= tid[bus.row_sel_to_pe_from_cr];
  end

  int checks   = 0;
  int failures = 0;

  int m_n, m_nlos, m_done;
  int m_los  [32];
  int m_strk [32];

  task automatic chk(input string nm, input int k, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", nm, k, act, exp);
    end
  endtask

  // Cycle numbering: start_cr is sampled at the edge that begins cycle 1.
  // Pair p is examined in cycle N+2+p and its strobe lands in cycle N+3+p.
  task automatic build_model(input int nr);
    bit lost [8];
    int p, npairs, l;
    m_n    = (nr > 8) ? 8 : nr;
    m_nlos = 0;
    npairs = m_n * (m_n - 1) / 2;
    p      = 0;
    m_done = (m_n == 0) ? 1 : m_n + 2 + npairs;
    for (int i = 0; i < 8; i++) lost[i] = 1'b0;
    for (int i = 0; i < m_n; i++) begin
      for (int j = i + 1; j < m_n; j++) begin
        if (!lost[i] && !lost[j] && tid[i] == tid[j] && tid[i] != 12'hFFF) begin
          l = (tsc[j] <= tsc[i]) ? j : i;
          lost[l] = 1'b1;
          m_los[m_nlos]  = l;
          m_strk[m_nlos] = m_n + 3 + p;
          m_nlos++;
          if (p == npairs - 1) m_done = m_done + 1;
        end
        p++;
      end
    end
  endtask

  task automatic run_pass(input string tag, input int nr, input int ign_k, input int abort_k,
                          input int lit_cnt, input int lit_done, input int lit_first);
    int kend, e_rsel, e_wr, e_row, e_cnt, e_done;
    build_model(nr);
    chk({tag, "_model_cnt"}, 0, m_nlos, lit_cnt);
    chk({tag, "_model_done"}, 0, m_done, lit_done);
    if (lit_cnt > 0) chk({tag, "_model_first_loser"}, 0, m_los[0], lit_first);
    bus.num_of_rows = 4'(nr);
    bus.start_cr    = 1'b1;
    kend = m_done + 2;
    for (int k = 1; k <= kend; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) bus.start_cr = 1'b0;
      if (ign_k > 0 && k == ign_k) bus.start_cr = 1'b1;
      else if (ign_k > 0 && k == ign_k + 1) bus.start_cr = 1'b0;
      e_rsel = (k <= m_n) ? k - 1 : 0;
      e_wr = 0; e_row = 0; e_cnt = 0;
      for (int s = 0; s < m_nlos; s++) begin
        if (m_strk[s] == k) begin e_wr = 1; e_row = m_los[s]; end
        if (m_strk[s] <= k) e_cnt++;
      end
      e_done = (k == m_done) ? 1 : 0;
      chk({tag, "_row_sel"}, k, int'(bus.row_sel_to_pe_from_cr), e_rsel);
      chk({tag, "_wr"}, k, int'(bus.write_to_pointer_to_pe), e_wr);
      chk({tag, "_data"}, k, int'(bus.data_to_score_board_to_pe), e_wr);
      if (e_wr == 1) chk({tag, "_row_to_change"}, k, int'(bus.row_to_change_to_pe), e_row);
      chk({tag, "_done"}, k, int'(bus.done_cr), e_done);
      chk({tag, "_cnt"}, k, int'(bus.conflict_cnt), e_cnt);
      if (k == abort_k) begin
        reset_N = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_rst_row_sel"}, k + 1, int'(bus.row_sel_to_pe_from_cr), 0);
        chk({tag, "_rst_wr"}, k + 1, int'(bus.write_to_pointer_to_pe), 0);
        chk({tag, "_rst_data"}, k + 1, int'(bus.data_to_score_board_to_pe), 0);
        chk({tag, "_rst_row"}, k + 1, int'(bus.row_to_change_to_pe), 0);
        chk({tag, "_rst_done"}, k + 1, int'(bus.done_cr), 0);
        chk({tag, "_rst_cnt"}, k + 1, int'(bus.conflict_cnt), 0);
        reset_N = 1'b0;
        return;
      end
    end
    chk({tag, "_final_cnt"}, kend, int'(bus.conflict_cnt), lit_cnt);
  endtask

  initial begin
    reset_N         = 1'b1;
    bus.start_cr    = 1'b0;
    bus.num_of_rows = '0;
    tid = '{12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0};
    tsc = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_row_sel", 0, int'(bus.row_sel_to_pe_from_cr), 0);
    chk("reset_wr", 0, int'(bus.write_to_pointer_to_pe), 0);
    chk("reset_done", 0, int'(bus.done_cr), 0);
    chk("reset_cnt", 0, int'(bus.conflict_cnt), 0);
    reset_N = 1'b0;

    tid = '{12'd1, 12'd2, 12'd3, 12'd4, 12'd0, 12'd0, 12'd0, 12'd0};
    tsc = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd0, 16'd0, 16'd0, 16'd0};
    run_pass("no_conflict", 4, 0, 0, 0, 12, 0);

    tid = '{12'd7, 12'd7, 12'd9, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0};
    tsc = '{16'd100, 16'd200, 16'd50, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    run_pass("simple", 3, 0, 0, 1, 8, 0);

    tid = '{12'd5, 12'd5, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0};
    tsc = '{16'd80, 16'd80, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    run_pass("tie", 2, 0, 0, 1, 6, 1);

    tid = '{12'd3, 12'd3, 12'd3, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0};
    tsc = '{16'd10, 16'd30, 16'd20, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    run_pass("triple", 3, 0, 0, 2, 9, 0);

    run_pass("empty", 0, 0, 0, 0, 1, 0);

    tid = '{12'hFFF, 12'hFFF, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0};
    tsc = '{16'd1, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    run_pass("no_cand", 2, 0, 0, 0, 5, 0);

    run_pass("single", 1, 0, 0, 0, 3, 0);

    // num_of_rows above ROWS clamps to 8; full-width scores above 255 and ties.
    tid = '{12'd1, 12'd2, 12'd1, 12'd3, 12'd2, 12'd4, 12'd5, 12'd5};
    tsc = '{16'd500, 16'd65535, 16'd500, 16'd6, 16'd40000, 16'd1, 16'd9, 16'd9};
    run_pass("clamp8", 12, 0, 0, 3, 39, 2);

    tid = '{12'd7, 12'd7, 12'd9, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0};
    tsc = '{16'd100, 16'd200, 16'd50, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    run_pass("ign_start", 3, 2, 0, 1, 8, 0);

    tid = '{12'd3, 12'd3, 12'd3, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0};
    tsc = '{16'd10, 16'd30, 16'd20, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    run_pass("abort", 3, 0, 5, 2, 9, 0);

    // Start in the very first cycle after reset release.
    tid = '{12'd7, 12'd7, 12'd9, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0};
    tsc = '{16'd100, 16'd200, 16'd50, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    run_pass("post_rst", 3, 0, 0, 1, 8, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/oflow_conflict_resolve.md
OFLOW_CONFLICT_RESOLVE -- requirements
Module: oflow_conflict_resolve

Interface
REQ-001 The module SHALL provide parameter ROWS, default 8, meaning the number of score-board rows per PE.
REQ-002 The module SHALL provide parameter ROW_LEN, default 3, meaning the row-index width (clog2 of ROWS).
REQ-003 The module SHALL provide parameter SCORE_LEN, default 16, meaning the score width (unsigned; higher value = better match).
REQ-004 The module SHALL provide parameter ID_LEN, default 12, meaning the ID width; all-ones means "no candidate".
REQ-005 The module SHALL provide port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The module SHALL provide port reset_N, input, 1 bit: synchronous, active-high reset (asserted = 1).
REQ-007 The module SHALL provide port start_cr, input, 1 bit: one-cycle start pulse from core_fsm.
REQ-008 The module SHALL provide port num_of_rows, input, ROW_LEN+1 bits: valid rows this frame; sampled on start.
REQ-009 The module SHALL provide port score_to_cr_from_pe, input, SCORE_LEN bits: score of the selected row, valid one cycle after select.
REQ-010 The module SHALL provide port id_to_cr_from_pe, input, ID_LEN bits: ID of the selected row, same timing as the score.
REQ-011 The module SHALL provide port row_sel_to_pe_from_cr, output, ROW_LEN bits: score-board read row.
REQ-012 The module SHALL provide port write_to_pointer_to_pe, output, 1 bit: one-cycle score-board write strobe.
REQ-013 The module SHALL provide port data_to_score_board_to_pe, output, 1 bit: fallback-advance flag; 1 whenever the strobe is high.
REQ-014 The module SHALL provide port row_to_change_to_pe, output, ROW_LEN bits: row written with the strobe.
REQ-015 The module SHALL provide port done_cr, output, 1 bit: one-cycle completion pulse.
REQ-016 The module SHALL provide port conflict_cnt, output, ROW_LEN+1 bits: number of losers this pass; held until the next start.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, COMPARE and DONE.
REQ-018 IDLE: when start_cr=1, the block SHALL latch N = min(num_of_rows, ROWS), clear the loser flags and conflict_cnt, and go to LOAD; if N=0 it SHALL go directly to DONE.
REQ-019 start_cr SHALL be ignored in every state except IDLE.
REQ-020 LOAD: the block SHALL drive row_sel = 0..N-1 on consecutive cycles and capture score/id for row k one cycle after row_sel = k into local arrays; LOAD SHALL last exactly N+1 cycles.
REQ-021 COMPARE: the block SHALL visit pairs (i,j), i<j<N, in order i-major then j ascending, one pair per cycle, for N(N-1)/2 cycles; N=1 SHALL skip to DONE.
REQ-022 A pair SHALL conflict iff id[i]==id[j], that ID is not all-ones, and neither row is already a loser.
REQ-023 On a conflict, the row with the lower score SHALL lose; on equal scores, row j SHALL lose.
REQ-024 The loser SHALL be flagged, conflict_cnt SHALL be incremented, and in the next cycle the block SHALL drive write_to_pointer_to_pe=1, data_to_score_board_to_pe=1 and row_to_change_to_pe=loser (registered, one-cycle pulse).
REQ-025 Strobes for consecutive conflicts SHALL be issued back-to-back, one per cycle, with no pair skipped or repeated.
REQ-026 DONE: done_cr SHALL be 1 for exactly one cycle, in the cycle after the last compare cycle (or after the last write strobe if that is later), and the FSM SHALL then return to IDLE.
REQ-027 row_sel_to_pe_from_cr SHALL be 0 outside LOAD.
REQ-028 Score comparison SHALL be unsigned full-width with no truncation.

Reset
REQ-029 While reset_N=1 at a clock edge, the FSM SHALL go to IDLE, and row_sel, the write strobe, data, row_to_change, done_cr, conflict_cnt and the loser flags SHALL all be 0.
REQ-030 Reset asserted mid-LOAD or mid-COMPARE SHALL abort the pass with no further strobes; a new start_cr SHALL be accepted in the first cycle after reset deasserts.

Verification
REQ-031 Bench scenario (no conflict): N=4, ids {1,2,3,4} -> no strobe; done_cr 5+6+1 cycles after start; conflict_cnt=0.
REQ-032 Bench scenario (simple conflict): N=3, ids {7,7,9}, scores {100,200,50} -> exactly one strobe with row_to_change=0; conflict_cnt=1.
REQ-033 Bench scenario (tie): N=2, ids {5,5}, scores {80,80} -> strobe row 1; done_cr follows.
REQ-034 Bench scenario (triple claim): N=3, ids {3,3,3}, scores {10,30,20} -> strobes row 0 (pair 0,1), then row 2 (pair 1,2); the (0,2) pair is skipped; conflict_cnt=2.
REQ-035 Bench scenario (empty/no-candidate): N=0 -> done_cr one cycle after start, no row_sel activity; N=2, ids all-ones -> no strobe.
REQ-036 Bench scenario (reset/ignored start): reset_N=1 during COMPARE -> all outputs 0 next cycle, no strobe; start_cr pulsed during LOAD -> ignored, pass completes normally.
